// File: rtl/cha_pkg.sv
// rtl/cha_pkg.sv - shared types and helpers for the CHA game-select receiver
package cha_pkg;

    localparam int GSEL_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FILTER,
        ST_REQ,
        ST_WAIT_REL
    } state_t;

    // ICON[9] and ICON[3] carry no code bits.
    function automatic logic [GSEL_W-1:0] icon_to_gsel(input logic [9:0] icon);
        return {icon[8:4], icon[2:0]};
    endfunction

endpackage

// File: rtl/sync2.sv
// rtl/sync2.sv - generic two-flop synchroniser, asynchronous active-low reset
module sync2 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/cha_gsel_rx.sv
// rtl/cha_gsel_rx.sv - ICON game-select receiver: sync, glitch filter, clamp, REQ/ACK commit
module cha_gsel_rx
    import cha_pkg::*;
#(
    parameter int          STABLE_CYCLES = 16,
    parameter logic [7:0]  MAX_GAME      = 8'd127,
    parameter int          ACK_TIMEOUT   = 1024
) (
    input  logic              CLK_24M,
    input  logic              nRESET,
    input  logic [9:0]        ICON,
    input  logic              ACK,
    output logic              REQ,
    output logic [GSEL_W-1:0] PEND_GSEL,
    output logic [GSEL_W-1:0] GSEL,
    output logic              CHANGE,
    output logic              BUSY,
    output logic              ERR
);

    localparam int                TO_W        = $clog2(ACK_TIMEOUT + 1);
    localparam logic [7:0]        STABLE_LAST = 8'(STABLE_CYCLES - 1);
    localparam logic [TO_W-1:0]   TO_LAST     = TO_W'(ACK_TIMEOUT - 1);

    logic [GSEL_W-1:0] code_sync;
    logic [GSEL_W-1:0] s_code;
    logic              ack_q;
    logic              oor;
    logic [GSEL_W-1:0] cand;

    state_t            state, state_n;
    logic [GSEL_W-1:0] pend, pend_n;
    logic [GSEL_W-1:0] gsel, gsel_n;
    logic [7:0]        cnt, cnt_n;
    logic [TO_W-1:0]   tcnt, tcnt_n;
    logic              change, change_n;
    logic              busy, busy_n;
    logic              err, err_n;

    sync2 #(.WIDTH(GSEL_W)) u_sync (
        .clk   (CLK_24M),
        .rst_n (nRESET),
        .d     (icon_to_gsel(ICON)),
        .q     (code_sync)
    );

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            s_code <= '0;
            ack_q  <= 1'b0;
        end else begin
            s_code <= code_sync;
            ack_q  <= ACK;
        end
    end

    assign oor  = (s_code > MAX_GAME);
    assign cand = oor ? '0 : s_code;

    always_ff @(posedge CLK_24M or negedge nRESET) begin
        if (!nRESET) begin
            state  <= ST_IDLE;
            pend   <= '0;
            gsel   <= '0;
            cnt    <= '0;
            tcnt   <= '0;
            change <= 1'b0;
            busy   <= 1'b0;
            err    <= 1'b0;
        end else begin
            state  <= state_n;
            pend   <= pend_n;
            gsel   <= gsel_n;
            cnt    <= cnt_n;
            tcnt   <= tcnt_n;
            change <= change_n;
            busy   <= busy_n;
            err    <= err_n;
        end
    end

    always_comb begin
        state_n  = state;
        pend_n   = pend;
        gsel_n   = gsel;
        cnt_n    = cnt;
        tcnt_n   = tcnt;
        change_n = 1'b0;
        err_n    = err | oor;
        case (state)
            ST_IDLE: begin
                if (cand != gsel) begin
                    pend_n  = cand;
                    cnt_n   = '0;
                    state_n = ST_FILTER;
                end
            end
            ST_FILTER: begin
                if (cand == gsel) begin
                    state_n = ST_IDLE;
                end else if (cand != pend) begin
                    pend_n = cand;
                    cnt_n  = '0;
                end else begin
                    if (cnt != 8'hFF) cnt_n = cnt + 8'd1;
                    // A still-high ACK belongs to the previous handshake; wait it out.
                    if (cnt >= STABLE_LAST && !ack_q) begin
                        tcnt_n  = '0;
                        state_n = ST_REQ;
                    end
                end
            end
            ST_REQ: begin
                if (ack_q) begin
                    gsel_n   = pend;
                    change_n = 1'b1;
                    state_n  = ST_WAIT_REL;
                end else if (tcnt == TO_LAST) begin
                    err_n   = 1'b1;
                    state_n = ST_WAIT_REL;
                end else begin
                    tcnt_n = tcnt + TO_W'(1);
                end
            end
            ST_WAIT_REL: begin
                if (!ack_q) state_n = ST_IDLE;
            end
            default: state_n = ST_IDLE;
        endcase
        busy_n = (state_n != ST_IDLE);
    end

    assign REQ       = (state == ST_REQ);
    assign PEND_GSEL = pend;
    assign GSEL      = gsel;
    assign CHANGE    = change;
    assign BUSY      = busy;
    assign ERR       = err;

endmodule

// File: tb/tb_cha_gsel_rx.sv
// tb/tb_cha_gsel_rx.sv - directed self-checking bench for cha_gsel_rx
module tb_cha_gsel_rx;

    logic       CLK_24M = 1'b0;
    logic       nRESET;
    logic [9:0] ICON;
    logic       ACK;
    logic       REQ;
    logic [7:0] PEND_GSEL;
    logic [7:0] GSEL;
    logic       CHANGE;
    logic       BUSY;
    logic       ERR;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 CLK_24M = ~CLK_24M;

    cha_gsel_rx #(
        .STABLE_CYCLES (16),
        .MAX_GAME      (8'd127),
        .ACK_TIMEOUT   (1024)
    ) dut (
        .CLK_24M   (CLK_24M),
        .nRESET    (nRESET),
        .ICON      (ICON),
        .ACK       (ACK),
        .REQ       (REQ),
        .PEND_GSEL (PEND_GSEL),
        .GSEL      (GSEL),
        .CHANGE    (CHANGE),
        .BUSY      (BUSY),
        .ERR       (ERR)
    );

    function automatic logic [9:0] to_icon(input logic [7:0] c, input logic junk);
        return {junk, c[7:3], junk, c[2:0]};
    endfunction

    task automatic tick;
        @(posedge CLK_24M);
        #1;
    endtask

    task automatic do_reset;
        nRESET = 1'b0;
        ACK    = 1'b0;
        ICON   = '0;
        tick;
        tick;
        nRESET = 1'b1;
        tick;
    endtask

    task automatic wait_req(input int bound, output int edges);
        edges = -1;
        for (int i = 1; i <= bound; i++) begin
            tick;
            if (REQ === 1'b1) begin
                edges = i;
                break;
            end
        end
    endtask

    task automatic handshake(input int delay, output logic [7:0] g, output int changes,
                             output logic busy_after);
        changes = 0;
        repeat (delay) begin
            tick;
            if (CHANGE === 1'b1) changes++;
        end
        ACK = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick;
            if (CHANGE === 1'b1) changes++;
            if (REQ === 1'b0) break;
        end
        ACK = 1'b0;
        repeat (4) begin
            tick;
            if (CHANGE === 1'b1) changes++;
        end
        g          = GSEL;
        busy_after = BUSY;
    endtask

    task automatic test_reset;
        nRESET = 1'b0;
        ACK    = 1'b0;
        ICON   = '0;
        tick;
        tick;
        n_cmp++; if ({REQ, CHANGE, BUSY, ERR, GSEL, PEND_GSEL} !== 20'h0) begin n_bad++;
            $display("FAIL reset_values: got %h expected 00000", {REQ, CHANGE, BUSY, ERR, GSEL, PEND_GSEL}); end
        nRESET = 1'b1;
        repeat (6) tick;
        n_cmp++; if ({REQ, BUSY, GSEL} !== 10'h0) begin n_bad++;
            $display("FAIL reset_idle_code0: got %h expected 000", {REQ, BUSY, GSEL}); end
    endtask

    task automatic test_basic_commit;
        int e;
        ICON = to_icon(8'h05, 1'b0);
        repeat (3) tick;
        n_cmp++; if (BUSY !== 1'b0) begin n_bad++; $display("FAIL t1_busy_early: got %b expected 0", BUSY); end
        tick;
        n_cmp++; if (BUSY !== 1'b1) begin n_bad++; $display("FAIL t1_busy_rise: got %b expected 1", BUSY); end
        wait_req(60, e);
        n_cmp++; if (e + 4 !== 20) begin n_bad++; $display("FAIL t1_req_latency: got %0d expected 20", e + 4); end
        n_cmp++; if (PEND_GSEL !== 8'h05) begin n_bad++; $display("FAIL t1_pend: got %h expected 05", PEND_GSEL); end
        repeat (3) tick;
        n_cmp++; if ({REQ, GSEL} !== 9'h100) begin n_bad++;
            $display("FAIL t1_req_hold: got %h expected 100", {REQ, GSEL}); end
        ACK = 1'b1;
        tick;
        n_cmp++; if ({REQ, CHANGE, GSEL} !== 10'h200) begin n_bad++;
            $display("FAIL t1_ack_sample: got %h expected 200", {REQ, CHANGE, GSEL}); end
        tick;
        n_cmp++; if ({REQ, CHANGE, GSEL} !== 10'h105) begin n_bad++;
            $display("FAIL t1_commit: got %h expected 105", {REQ, CHANGE, GSEL}); end
        ACK = 1'b0;
        tick;
        n_cmp++; if ({CHANGE, BUSY} !== 2'b01) begin n_bad++;
            $display("FAIL t1_change_width: got %b expected 01", {CHANGE, BUSY}); end
        tick;
        n_cmp++; if ({BUSY, GSEL} !== 9'h005) begin n_bad++;
            $display("FAIL t1_busy_fall: got %h expected 005", {BUSY, GSEL}); end
    endtask

    task automatic test_glitch;
        int e, reqs, ch;
        logic [7:0] g;
        logic b;
        reqs = 0;
        for (int seg = 0; seg < 20; seg++) begin
            ICON = to_icon((seg % 2 == 0) ? 8'h06 : 8'h05, 1'b0);
            repeat (10) begin
                tick;
                if (REQ === 1'b1) reqs++;
            end
        end
        n_cmp++; if (reqs !== 0) begin n_bad++; $display("FAIL t2_no_req_toggle: got %0d REQ cycles expected 0", reqs); end
        ICON = to_icon(8'h06, 1'b0);
        wait_req(60, e);
        n_cmp++; if (e !== 20) begin n_bad++; $display("FAIL t2_settle_latency: got %0d expected 20", e); end
        handshake(3, g, ch, b);
        n_cmp++; if ({g, ch[3:0], b} !== {8'h06, 4'd1, 1'b0}) begin n_bad++;
            $display("FAIL t2_commit: gsel=%h changes=%0d busy=%b expected 06 1 0", g, ch, b); end
    endtask

    task automatic test_clamp;
        int e, ch, reqs, busys;
        logic [7:0] g;
        logic b;
        ICON = to_icon(8'h03, 1'b0);
        wait_req(60, e);
        handshake(3, g, ch, b);
        n_cmp++; if ({g, ERR} !== {8'h03, 1'b0}) begin n_bad++;
            $display("FAIL t3_setup: gsel=%h err=%b expected 03 0", g, ERR); end
        ICON = to_icon(8'hC8, 1'b0);
        wait_req(60, e);
        n_cmp++; if ({e[7:0], PEND_GSEL, ERR} !== {8'd20, 8'h00, 1'b1}) begin n_bad++;
            $display("FAIL t3_clamp_req: edges=%0d pend=%h err=%b expected 20 00 1", e, PEND_GSEL, ERR); end
        handshake(3, g, ch, b);
        n_cmp++; if ({g, ch[3:0]} !== {8'h00, 4'd1}) begin n_bad++;
            $display("FAIL t3_clamp_commit: gsel=%h changes=%0d expected 00 1", g, ch); end
        do_reset;
        n_cmp++; if (ERR !== 1'b0) begin n_bad++; $display("FAIL t3_err_reset: got %b expected 0", ERR); end
        ICON = to_icon(8'hC8, 1'b0);
        reqs  = 0;
        busys = 0;
        repeat (30) begin
            tick;
            if (REQ === 1'b1) reqs++;
            if (BUSY === 1'b1) busys++;
        end
        n_cmp++; if ({reqs[7:0], busys[7:0], ERR, GSEL} !== {8'd0, 8'd0, 1'b1, 8'h00}) begin n_bad++;
            $display("FAIL t3_clamp_equal: req=%0d busy=%0d err=%b gsel=%h expected 0 0 1 00", reqs, busys, ERR, GSEL); end
    endtask

    task automatic test_timeout;
        int e, hold, ch;
        logic [7:0] g;
        logic b;
        do_reset;
        ICON = to_icon(8'h0A, 1'b1);
        wait_req(60, e);
        n_cmp++; if ({e[7:0], PEND_GSEL, ERR} !== {8'd20, 8'h0A, 1'b0}) begin n_bad++;
            $display("FAIL t4_req: edges=%0d pend=%h err=%b expected 20 0a 0", e, PEND_GSEL, ERR); end
        hold = -1;
        ch   = 0;
        for (int i = 1; i <= 1100; i++) begin
            tick;
            if (CHANGE === 1'b1) ch++;
            if (REQ === 1'b0) begin
                hold = i;
                break;
            end
        end
        n_cmp++; if (hold !== 1024) begin n_bad++; $display("FAIL t4_timeout_len: got %0d expected 1024", hold); end
        n_cmp++; if ({ERR, GSEL, ch[3:0]} !== {1'b1, 8'h00, 4'd0}) begin n_bad++;
            $display("FAIL t4_timeout_state: err=%b gsel=%h changes=%0d expected 1 00 0", ERR, GSEL, ch); end
        wait_req(60, e);
        n_cmp++; if (e !== 18) begin n_bad++; $display("FAIL t4_retry_latency: got %0d expected 18", e); end
        handshake(3, g, ch, b);
        n_cmp++; if ({g, ch[3:0], b} !== {8'h0A, 4'd1, 1'b0}) begin n_bad++;
            $display("FAIL t4_retry_commit: gsel=%h changes=%0d busy=%b expected 0a 1 0", g, ch, b); end
    endtask

    task automatic test_ack_early;
        int reqs, ch;
        logic [7:0] g;
        logic b;
        ACK = 1'b1;
        tick;
        ICON = to_icon(8'h11, 1'b0);
        reqs = 0;
        repeat (40) begin
            tick;
            if (REQ === 1'b1) reqs++;
        end
        n_cmp++; if ({reqs[7:0], BUSY, PEND_GSEL} !== {8'd0, 1'b1, 8'h11}) begin n_bad++;
            $display("FAIL t5_held_off: req=%0d busy=%b pend=%h expected 0 1 11", reqs, BUSY, PEND_GSEL); end
        ACK = 1'b0;
        tick;
        n_cmp++; if (REQ !== 1'b0) begin n_bad++; $display("FAIL t5_ack_sync: got %b expected 0", REQ); end
        tick;
        n_cmp++; if (REQ !== 1'b1) begin n_bad++; $display("FAIL t5_req_after_ack: got %b expected 1", REQ); end
        handshake(3, g, ch, b);
        n_cmp++; if ({g, ch[3:0]} !== {8'h11, 4'd1}) begin n_bad++;
            $display("FAIL t5_commit: gsel=%h changes=%0d expected 11 1", g, ch); end
    endtask

    task automatic test_reset_mid;
        int e, ch;
        logic [7:0] g;
        logic b;
        ICON = to_icon(8'h22, 1'b0);
        wait_req(60, e);
        n_cmp++; if (e !== 20) begin n_bad++; $display("FAIL t6_req: got %0d expected 20", e); end
        #1;
        nRESET = 1'b0;
        #1;
        n_cmp++; if ({REQ, BUSY, ERR, GSEL} !== 11'h000) begin n_bad++;
            $display("FAIL t6_async_reset: got %h expected 000", {REQ, BUSY, ERR, GSEL}); end
        tick;
        tick;
        nRESET = 1'b1;
        wait_req(60, e);
        n_cmp++; if ({e[7:0], PEND_GSEL} !== {8'd20, 8'h22}) begin n_bad++;
            $display("FAIL t6_rerequest: edges=%0d pend=%h expected 20 22", e, PEND_GSEL); end
        handshake(3, g, ch, b);
        n_cmp++; if ({g, ch[3:0], b} !== {8'h22, 4'd1, 1'b0}) begin n_bad++;
            $display("FAIL t6_commit: gsel=%h changes=%0d busy=%b expected 22 1 0", g, ch, b); end
    endtask

    initial begin
        nRESET = 1'b0;
        ACK    = 1'b0;
        ICON   = '0;
        test_reset;
        test_basic_commit;
        test_glitch;
        test_clamp;
        test_timeout;
        test_ack_early;
        test_reset_mid;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cha_gsel_rx.md
# cha_gsel_rx

Clocked receiver for the game-select code broadcast by the PROG CPLD on the 10-line ICON bus. It sits in the CHA CPLD.
- Synchronises the asynchronous ICON lines into the 24 MHz domain and filters out glitches while the 68K write settles.
- Clamps codes above the highest installed game to 0.
- Commits a new code to the local bank mapper through a four-phase REQ/ACK handshake, so C-ROM/S-ROM addressing never changes mid-fetch.

## Interface
Parameters:
- STABLE_CYCLES, 16: consecutive identical synchronised samples required before a code is accepted (range 2..255).
- MAX_GAME, 8'd127: highest valid game index; larger codes are clamped to 0.
- ACK_TIMEOUT, 1024: cycles to wait for ACK before abandoning a request.

Ports:
- CLK_24M  in  1  system clock. One clock domain.
- nRESET  in  1  reset, asynchronous assert, active-low.
- ICON  in  10  game-select bus from the PROG CPLD; code = {ICON[8:4], ICON[2:0]}; ICON[9] and ICON[3] are ignored.
- ACK  in  1  mapper acknowledge (four-phase).
- REQ  out  1  request to the mapper; PEND_GSEL is valid while it is high.
- PEND_GSEL  out  8  candidate code offered with REQ.
- GSEL  out  8  committed game-select code.
- CHANGE  out  1  one-cycle pulse when GSEL updates.
- BUSY  out  1  high in every state except IDLE.
- ERR  out  1  sticky flag: an out-of-range code was seen, or an ACK timeout occurred.

## Operation
- Input path: ICON passes through 2-FF synchronisers (reset 0), then a sample register S. The code is reconstructed from the synchronised bits. If code > MAX_GAME, the candidate C is 0 and ERR is set; otherwise C equals the code.
- FSM states: IDLE, FILTER, REQ, WAIT_REL.
  - IDLE: if C != GSEL, load PEND_GSEL <= C, clear the counter and go to FILTER. If C == GSEL, stay.
  - FILTER: each cycle with C == PEND_GSEL, increment the counter. If C differs, load PEND_GSEL <= C and clear the counter.
    - If C == GSEL, go back to IDLE (glitch returned to the committed value).
    - When the counter reaches STABLE_CYCLES-1 and ACK is low, go to REQ. If ACK is high, hold FILTER with the counter saturated.
  - REQ: REQ=1 and PEND_GSEL frozen; ICON changes are ignored. The timeout counter runs.
    - ACK high: GSEL <= PEND_GSEL, CHANGE pulse, go to WAIT_REL.
    - Timeout reached with no ACK: set ERR, keep GSEL, go to WAIT_REL.
  - WAIT_REL: REQ=0. Wait for ACK low, then go to IDLE, where the current C is re-evaluated.
- Width and arithmetic:
  - Filter counter is 8 bits and saturates.
  - Timeout counter is ceil(log2(ACK_TIMEOUT+1)) bits and is cleared on entry to REQ.
- ERR clears only on reset.

## Timing
- Reset values: GSEL=0, PEND_GSEL=0, REQ=0, CHANGE=0, BUSY=0, ERR=0, state IDLE, all counters 0. Asserting nRESET mid-handshake drops REQ immediately (asynchronous).
- Latency from an ICON change to REQ high, with ACK low: 2 (sync) + 1 (S) + 1 (IDLE→FILTER) + STABLE_CYCLES = STABLE_CYCLES+4 rising edges.
- With ACK sampled high in REQ at edge k:
  - GSEL and CHANGE update at edge k+1.
  - REQ is low after edge k+1.
  - CHANGE is high for exactly one cycle.
- REQ never rises while ACK is high, and never falls before ACK is sampled high or the timeout fires.
- BUSY is registered and follows the state, so it rises on the edge that leaves IDLE.
- Simultaneous events:
  - Timeout and ACK in the same cycle: ACK wins.
  - Out-of-range code during FILTER: ERR is set on that cycle, and filtering continues with C=0.

## Structure
- Package cha_pkg holds:
  - the state enum (IDLE, FILTER, REQ, WAIT_REL);
  - GSEL_W = 8;
  - the function icon_to_gsel(ICON) implementing {ICON[8:4], ICON[2:0]}.
- Sub-module sync2, a generic width 2-FF synchroniser with asynchronous active-low reset, instantiated with width 8.

## Test plan
- Reset, then drive ICON code 0x05 with ACK tied to a 3-cycle-delay responder → REQ rises 20 cycles after the change, PEND_GSEL=0x05, GSEL=0x05, one CHANGE pulse, BUSY returns low.
- ICON toggles 0x05↔0x06 every 10 cycles for 200 cycles, then settles at 0x06 → no REQ during toggling; a single commit of 0x06 after STABLE_CYCLES.
- Code 0xC8 with MAX_GAME=127 and GSEL=0x03 → ERR=1 and a commit of 0x00. Code 0xC8 with GSEL=0 → ERR=1, no REQ.
- ACK held low in REQ → after 1024 cycles REQ drops, ERR=1, GSEL is unchanged, then IDLE is re-entered and the request is retried.
- ACK high before FILTER completes → REQ is held off until ACK is low, then asserts the next cycle.
- nRESET pulsed while REQ=1 → REQ=0 and GSEL=0 asynchronously. After release, the still-present code is re-filtered and requested again.
